// File: rtl/controlador_exibicao_pkg.sv
// Shared definitions for the sequence playback controller: state encodings,
// debug codes and a small sizing helper.
package controlador_exibicao_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [2:0] DB_INVALIDO = 3'd7;

    function automatic int max_ciclos(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controlador_exibicao_contador_m.sv
// Generic modulo-M counter: synchronous clear (zera) has priority over count
// enable (conta); fim flags the terminal value M-1.
module contador_m #(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] q,
    output logic         fim
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] q_r;

    // counter register with wrap at M-1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else if (zera) begin
            q_r <= '0;
        end else if (conta) begin
            if (q_r == ULTIMO) begin
                q_r <= '0;
            end else begin
                q_r <= q_r + N'(1);
            end
        end else begin
            q_r <= q_r;
        end
    end

    assign q   = q_r;
    assign fim = (q_r == ULTIMO);

endmodule

// File: rtl/controlador_exibicao.sv
// Plays back sequence memory entries 0..limite on the LEDs (lit T_ON cycles,
// blank T_OFF cycles each), then pulses pronto.
module controlador_exibicao
    import controlador_exibicao_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500,
    parameter int TMR_W  = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              leds_ativo,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam int             T_MAX   = max_ciclos(T_ON, T_OFF);
    localparam logic [TMR_W-1:0] ON_ULT  = TMR_W'(T_ON - 1);
    localparam logic [TMR_W-1:0] OFF_ULT = TMR_W'(T_OFF - 1);

    estado_t           estado_r;
    estado_t           estado_prox_s;
    logic [ADDR_W-1:0] endereco_r;
    logic [ADDR_W-1:0] limite_r;
    logic [DATA_W-1:0] leds_r;
    logic [TMR_W-1:0]  timer_s;
    logic              timer_fim_s;
    logic              fim_on_s;
    logic              fim_off_s;
    logic              zera_s;
    logic              conta_s;

    contador_m #(
        .M (T_MAX),
        .N (TMR_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_s),
        .conta   (conta_s),
        .q       (timer_s),
        .fim     (timer_fim_s)
    );

    // The longer phase can reuse the counter's own terminal flag.
    assign fim_on_s  = (T_ON  == T_MAX) ? timer_fim_s : (timer_s == ON_ULT);
    assign fim_off_s = (T_OFF == T_MAX) ? timer_fim_s : (timer_s == OFF_ULT);

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // next-state logic; abortar overrides everything
    always_comb begin
        estado_prox_s = estado_r;
        if (abortar) begin
            estado_prox_s = OCIOSO;
        end else begin
            case (estado_r)
                OCIOSO:  estado_prox_s = iniciar ? CARREGA : OCIOSO;
                CARREGA: estado_prox_s = ACENDE;
                ACENDE:  estado_prox_s = fim_on_s ? APAGA : ACENDE;
                APAGA: begin
                    if (!fim_off_s) begin
                        estado_prox_s = APAGA;
                    end else if (endereco_r == limite_r) begin
                        estado_prox_s = FIM;
                    end else begin
                        estado_prox_s = CARREGA;
                    end
                end
                FIM:     estado_prox_s = OCIOSO;
                default: estado_prox_s = OCIOSO;
            endcase
        end
    end

    // address, latched limit and LED pattern registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            endereco_r <= '0;
            limite_r   <= '0;
            leds_r     <= '0;
        end else if (abortar) begin
            endereco_r <= '0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (iniciar) begin
                        endereco_r <= '0;
                        limite_r   <= limite;
                    end
                end
                CARREGA: leds_r <= dado_mem;
                APAGA: begin
                    // increment only below the limit, so the address never wraps
                    if (fim_off_s && (endereco_r != limite_r)) begin
                        endereco_r <= endereco_r + ADDR_W'(1);
                    end
                end
                default: endereco_r <= endereco_r;
            endcase
        end
    end

    // Moore output decode and timer control
    always_comb begin
        leds       = '0;
        leds_ativo = 1'b0;
        ocupado    = 1'b1;
        pronto     = 1'b0;
        db_estado  = DB_INVALIDO;
        conta_s    = 1'b0;
        zera_s     = 1'b1;
        case (estado_r)
            OCIOSO: begin
                ocupado   = 1'b0;
                db_estado = 3'd0;
            end
            CARREGA: db_estado = 3'd1;
            ACENDE: begin
                leds       = leds_r;
                leds_ativo = 1'b1;
                db_estado  = 3'd2;
                conta_s    = 1'b1;
                zera_s     = fim_on_s;
            end
            APAGA: begin
                db_estado = 3'd3;
                conta_s   = 1'b1;
                zera_s    = fim_off_s;
            end
            FIM: begin
                pronto    = 1'b1;
                db_estado = 3'd4;
            end
            default: begin
                ocupado   = 1'b0;
                db_estado = DB_INVALIDO;
            end
        endcase
        if (abortar) begin
            zera_s = 1'b1;
        end else begin
            zera_s = zera_s;
        end
    end

    assign endereco = endereco_r;

endmodule

// File: tb/tb_controlador_exibicao.sv
// Directed bench for controlador_exibicao with T_ON=4, T_OFF=2 and a
// ROM holding 1,2,4,8 repeating.
module tb_controlador_exibicao;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       iniciar  = 1'b0;
    logic       abortar  = 1'b0;
    logic [3:0] limite   = 4'd0;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       leds_ativo;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;
    logic [3:0] um = 4'b0001;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign dado_mem = um << endereco[1:0];

    controlador_exibicao #(
        .ADDR_W (4),
        .DATA_W (4),
        .T_ON   (4),
        .T_OFF  (2),
        .TMR_W  (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .iniciar    (iniciar),
        .abortar    (abortar),
        .limite     (limite),
        .dado_mem   (dado_mem),
        .endereco   (endereco),
        .leds       (leds),
        .leds_ativo (leds_ativo),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .db_estado  (db_estado)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rom_m(input int a);
        logic [3:0] v;
        v = 4'b0001;
        return v << (a % 4);
    endfunction

    task automatic start(input int lim);
        limite  = 4'(lim);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        limite  = ~4'(lim);
    endtask

    // Phase t within an entry: 0 CARREGA, 1..4 ACENDE, 5..6 APAGA; FIM after the last entry.
    task automatic run_seq(input int lim, input int inj_t);
        int total;
        int ph;
        int ent;
        logic [2:0] st;
        logic [3:0] exp_leds;
        total = 7 * (lim + 1);
        start(lim);
        for (int t = 0; t <= total; t++) begin
            ph  = t % 7;
            ent = (t / 7 > lim) ? lim : t / 7;
            if (t == total)  st = 3'd4;
            else if (ph == 0) st = 3'd1;
            else if (ph <= 4) st = 3'd2;
            else             st = 3'd3;
            exp_leds = (st == 3'd2) ? rom_m(ent) : 4'd0;
            chk("db_estado", 8'(db_estado), 8'(st));
            chk("leds", 8'(leds), 8'(exp_leds));
            chk("leds_ativo", 8'(leds_ativo), 8'(st == 3'd2));
            chk("endereco", 8'(endereco), 8'(ent));
            chk("pronto", 8'(pronto), 8'(st == 3'd4));
            chk("ocupado", 8'(ocupado), 8'd1);
            if (t == inj_t) iniciar = 1'b1;
            tick();
            iniciar = 1'b0;
        end
        chk("fim_estado", 8'(db_estado), 8'd0);
        chk("fim_ocupado", 8'(ocupado), 8'd0);
        chk("fim_pronto", 8'(pronto), 8'd0);
        chk("fim_endereco", 8'(endereco), 8'(lim));
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_leds", 8'(leds), 8'd0);
        chk("rst_ativo", 8'(leds_ativo), 8'd0);
        chk("rst_ocupado", 8'(ocupado), 8'd0);
        chk("rst_pronto", 8'(pronto), 8'd0);
        chk("rst_estado", 8'(db_estado), 8'd0);
        chk("rst_endereco", 8'(endereco), 8'd0);
        #20;
        reset_n = 1'b1;
        tick();

        // abortar together with iniciar in OCIOSO stays idle
        abortar = 1'b1;
        iniciar = 1'b1;
        limite  = 4'd3;
        tick();
        abortar = 1'b0;
        iniciar = 1'b0;
        chk("abort_ini_estado", 8'(db_estado), 8'd0);
        chk("abort_ini_ocupado", 8'(ocupado), 8'd0);

        // test 1: four entries, limite changed after start has no effect
        run_seq(3, -1);
        // test 2: single entry
        run_seq(0, -1);
        // test 3: iniciar pulsed during the first ACENDE is ignored
        run_seq(3, 2);

        // test 4: abort during APAGA of the second entry
        start(3);
        for (int t = 0; t < 12; t++) tick();
        chk("pre_abort_estado", 8'(db_estado), 8'd3);
        chk("pre_abort_endereco", 8'(endereco), 8'd1);
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        chk("abort_estado", 8'(db_estado), 8'd0);
        chk("abort_leds", 8'(leds), 8'd0);
        chk("abort_ocupado", 8'(ocupado), 8'd0);
        chk("abort_endereco", 8'(endereco), 8'd0);
        for (int t = 0; t < 20; t++) begin
            chk("abort_pronto", 8'(pronto), 8'd0);
            tick();
        end
        run_seq(3, -1);

        // test 5: asynchronous reset in ACENDE
        start(3);
        tick();
        tick();
        chk("pre_rst_estado", 8'(db_estado), 8'd2);
        chk("pre_rst_leds", 8'(leds), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_leds", 8'(leds), 8'd0);
        chk("arst_ativo", 8'(leds_ativo), 8'd0);
        chk("arst_ocupado", 8'(ocupado), 8'd0);
        chk("arst_estado", 8'(db_estado), 8'd0);
        #3;
        reset_n = 1'b1;
        tick();
        chk("post_rst_estado", 8'(db_estado), 8'd0);
        chk("post_rst_pronto", 8'(pronto), 8'd0);
        chk("post_rst_endereco", 8'(endereco), 8'd0);
        tick();

        // test 6: full memory, endereco stops at 15
        run_seq(15, -1);
        tick();
        chk("full_endereco_hold", 8'(endereco), 8'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
